// File: rtl/tdm_slot_scheduler.sv
// tdm_slot_scheduler: sequences three source streams into one time-division output, one 3-slot frame per symbol_tick
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   symbol_tick  1-cycle frame-start strobe
//   mode         slot pattern: 0,1 = S1,S1,S1; 2 = S1,S2,S1; 3 = S1,S2,S3
//   slot_cycles  slot length minus one
//   ds_valid     bit k: source k+1 holds a word
//   ds1_data..ds3_data  source words
//   ds_ack       1-cycle capture pulse per source
//   out_data     scheduled word, held for the slot
//   out_sel      active source 1..3, 0 when idle
//   out_valid    slot active with a valid word
//   frame_start  pulse in the first cycle of slot 0
//   underrun     pulse: selected source empty at slot start
//   overrun      pulse: symbol_tick arrived mid-frame
module tdm_slot_scheduler #(
   parameter int                DATA_W   = 3,
   parameter logic [DATA_W-1:0] IDLE_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              symbol_tick,
   input  logic [1:0]        mode,
   input  logic [1:0]        slot_cycles,
   input  logic [2:0]        ds_valid,
   input  logic [DATA_W-1:0] ds1_data,
   input  logic [DATA_W-1:0] ds2_data,
   input  logic [DATA_W-1:0] ds3_data,
   output logic [2:0]        ds_ack,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_sel,
   output logic              out_valid,
   output logic              frame_start,
   output logic              underrun,
   output logic              overrun
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;
   logic [0:0]        state;
   logic [1:0]        cyc_cnt, slot_idx, mode_q, sc_q;
   logic              wrap, last, start, src_valid;
   logic [1:0]        nslot, nmode, src;
   logic [DATA_W-1:0] src_data;
   // A tick restarts at slot 0 with the incoming config; otherwise the next slot uses the latched config.
   always_comb begin
      wrap      = state == RUN && cyc_cnt == sc_q;
      last      = wrap && slot_idx == 2'd2;
      start     = symbol_tick || (wrap && !last);
      nslot     = symbol_tick ? 2'd0 : slot_idx + 2'd1;
      nmode     = symbol_tick ? mode : mode_q;
      src       = nslot == 2'd0 ? 2'd1 : nslot == 2'd1 ? (nmode[1] ? 2'd2 : 2'd1) : (nmode == 2'd3 ? 2'd3 : 2'd1);
      src_valid = ds_valid[src - 2'd1];
      src_data  = src == 2'd1 ? ds1_data : src == 2'd2 ? ds2_data : ds3_data;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cyc_cnt     <= '0;
         slot_idx    <= '0;
         mode_q      <= '0;
         sc_q        <= '0;
         out_data    <= IDLE_VAL;
         out_sel     <= '0;
         out_valid   <= 1'b0;
         ds_ack      <= '0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         frame_start <= symbol_tick;
         // A tick on the frame's final cycle is a seamless restart, not an overrun.
         overrun     <= symbol_tick && state == RUN && !last;
         ds_ack      <= '0;
         underrun    <= 1'b0;
         if (symbol_tick) begin
            state  <= RUN;
            mode_q <= mode;
            sc_q   <= slot_cycles;
         end
         if (start) begin
            cyc_cnt   <= '0;
            slot_idx  <= nslot;
            out_sel   <= src;
            out_valid <= src_valid;
            out_data  <= src_valid ? src_data : IDLE_VAL;
            ds_ack    <= src_valid ? 3'b001 << (src - 2'd1) : 3'b000;
            underrun  <= !src_valid;
         end else if (last) begin
            state     <= IDLE;
            cyc_cnt   <= '0;
            slot_idx  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            out_data  <= IDLE_VAL;
         end else if (state == RUN) begin
            cyc_cnt <= cyc_cnt + 2'd1;
         end
      end
   end
endmodule

// File: tb/tb_tdm_slot_scheduler.sv
// tb_tdm_slot_scheduler: directed table-driven bench for tdm_slot_scheduler
module tb_tdm_slot_scheduler;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       symbol_tick;
   logic [1:0] mode, slot_cycles;
   logic [2:0] ds_valid;
   logic [2:0] ds1_data, ds2_data, ds3_data;
   logic [2:0] ds_ack;
   logic [2:0] out_data;
   logic [1:0] out_sel;
   logic       out_valid, frame_start, underrun, overrun;
   int checks = 0;
   int failures = 0;

   tdm_slot_scheduler dut (
      .clk(clk), .rst_n(rst_n), .symbol_tick(symbol_tick), .mode(mode), .slot_cycles(slot_cycles),
      .ds_valid(ds_valid), .ds1_data(ds1_data), .ds2_data(ds2_data), .ds3_data(ds3_data),
      .ds_ack(ds_ack), .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
      .frame_start(frame_start), .underrun(underrun), .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       tick;
      logic [1:0] mode, sc;
      logic [2:0] valid;
      logic [2:0] ed;
      logic [1:0] esel;
      logic       ev;
      logic [2:0] eack;
      logic       efs, eur, eov;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic t, logic [1:0] m, logic [1:0] s, logic [2:0] v, logic [2:0] d,
                               logic [1:0] sel, logic ov, logic [2:0] a, logic fs, logic ur, logic orn);
      vec_t r;
      r.tick = t; r.mode = m; r.sc = s; r.valid = v; r.ed = d; r.esel = sel; r.ev = ov;
      r.eack = a; r.efs = fs; r.eur = ur; r.eov = orn;
      return r;
   endfunction

   task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, idx, act, exp);
      end
   endtask

   task automatic chk_all(int idx, logic [2:0] d, logic [1:0] sel, logic v, logic [2:0] a,
                          logic fs, logic ur, logic orn);
      chk("out_data", idx, 32'(out_data), 32'(d));
      chk("out_sel", idx, 32'(out_sel), 32'(sel));
      chk("out_valid", idx, 32'(out_valid), 32'(v));
      chk("ds_ack", idx, 32'(ds_ack), 32'(a));
      chk("frame_start", idx, 32'(frame_start), 32'(fs));
      chk("underrun", idx, 32'(underrun), 32'(ur));
      chk("overrun", idx, 32'(overrun), 32'(orn));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // test 1: mode 3, two-cycle slots, all valid
      vecs.push_back(mk(1, 3, 1, 7, 1, 1, 1, 1, 1, 0, 0));
      vecs.push_back(mk(0, 3, 1, 7, 1, 1, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 3, 1, 7, 2, 2, 1, 2, 0, 0, 0));
      vecs.push_back(mk(0, 3, 1, 7, 2, 2, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 3, 1, 7, 3, 3, 1, 4, 0, 0, 0));
      vecs.push_back(mk(0, 3, 1, 7, 3, 3, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 3, 1, 7, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 3, 1, 7, 0, 0, 0, 0, 0, 0, 0));
      // test 2: mode 2, single-cycle slots, source 1 acked twice
      vecs.push_back(mk(1, 2, 0, 7, 1, 1, 1, 1, 1, 0, 0));
      vecs.push_back(mk(0, 2, 0, 7, 2, 2, 1, 2, 0, 0, 0));
      vecs.push_back(mk(0, 2, 0, 7, 1, 1, 1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 2, 0, 7, 0, 0, 0, 0, 0, 0, 0));
      // test 3: no source valid, underrun each slot start
      vecs.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 1, 1, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 1, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      // test 4: four-cycle slots, abort tick mid-slot-1, then seamless restart on the last cycle
      vecs.push_back(mk(1, 3, 3, 7, 1, 1, 1, 1, 1, 0, 0));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 3, 3, 7, 1, 1, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 3, 3, 7, 2, 2, 1, 2, 0, 0, 0));
      vecs.push_back(mk(1, 3, 3, 7, 1, 1, 1, 1, 1, 0, 1));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 3, 3, 7, 1, 1, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 3, 3, 7, 2, 2, 1, 2, 0, 0, 0));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 3, 3, 7, 2, 2, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 3, 3, 7, 3, 3, 1, 4, 0, 0, 0));
      for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 3, 3, 7, 3, 3, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 3, 0, 7, 1, 1, 1, 1, 1, 0, 0));
      vecs.push_back(mk(0, 3, 0, 7, 2, 2, 1, 2, 0, 0, 0));
      vecs.push_back(mk(0, 3, 0, 7, 3, 3, 1, 4, 0, 0, 0));
      vecs.push_back(mk(0, 3, 0, 7, 0, 0, 0, 0, 0, 0, 0));
      // test 5: mode changed mid-frame only affects the next frame
      vecs.push_back(mk(1, 3, 0, 7, 1, 1, 1, 1, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 7, 2, 2, 1, 2, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 7, 3, 3, 1, 4, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 7, 1, 1, 1, 1, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 7, 1, 1, 1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 7, 1, 1, 1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0));

      rst_n = 1'b0; symbol_tick = 1'b0; mode = 2'd0; slot_cycles = 2'd0;
      ds_valid = 3'b111; ds1_data = 3'd1; ds2_data = 3'd2; ds3_data = 3'd3;
      step();
      step();
      chk_all(-1, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      step();
      chk_all(-2, 0, 0, 0, 0, 0, 0, 0);

      foreach (vecs[i]) begin
         symbol_tick = vecs[i].tick; mode = vecs[i].mode;
         slot_cycles = vecs[i].sc; ds_valid = vecs[i].valid;
         step();
         chk_all(i, vecs[i].ed, vecs[i].esel, vecs[i].ev, vecs[i].eack, vecs[i].efs, vecs[i].eur, vecs[i].eov);
      end
      symbol_tick = 1'b0;

      // data change mid-slot is ignored, then async reset in slot 1
      mode = 2'd3; slot_cycles = 2'd1; ds_valid = 3'b111;
      symbol_tick = 1'b1;
      step();
      symbol_tick = 1'b0;
      step();
      step();
      chk_all(100, 2, 2, 1, 2, 0, 0, 0);
      ds2_data = 3'd5;
      step();
      chk_all(101, 2, 2, 1, 0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      chk_all(102, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk_all(103, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1; ds2_data = 3'd2;
      step();
      symbol_tick = 1'b1;
      step();
      symbol_tick = 1'b0;
      chk_all(104, 1, 1, 1, 1, 1, 0, 0);
      step();
      step();
      chk_all(105, 2, 2, 1, 2, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
